// File: rtl/fpadd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpadd_ctrl_pkg
// Shared definitions for controllers that front a multi-cycle fpadd unit.
//   FP_W        : IEEE-754 single-precision word width
//   FP_QNAN     : quiet NaN returned on an aborted operation
//   DEF_TIMEOUT : default watchdog limit in WAIT cycles
//   fsm_state_t : sequencing states of the shared-adder controller
// ---------------------------------------------------------------------------
package fpadd_ctrl_pkg;

  localparam int              FP_W        = 32;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;
  localparam int              DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ABORT
  } fsm_state_t;

endpackage

// File: rtl/fpadd_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpadd_arbiter_if
// Client-side bus between N requesters and the shared-adder arbiter.
//   req       : per-requester request level, held until the gnt bit pulses
//   op_a/op_b : flattened operands, slot i = bits [32i+31:32i]
//   gnt       : one-hot, one-cycle accept pulse
//   rsp_valid : one-hot, one-cycle response pulse to the owning requester
//   rsp_sum   : result word, valid while any rsp_valid bit is high
//   rsp_err   : high with rsp_valid when the operation was aborted
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fpadd_arbiter_if #(
  parameter int N = 4
) ();

  logic [N-1:0]                        req;
  logic [N*fpadd_ctrl_pkg::FP_W-1:0]   op_a;
  logic [N*fpadd_ctrl_pkg::FP_W-1:0]   op_b;
  logic [N-1:0]                        gnt;
  logic [N-1:0]                        rsp_valid;
  logic [fpadd_ctrl_pkg::FP_W-1:0]     rsp_sum;
  logic                                rsp_err;

  modport master (
    output req, op_a, op_b,
    input  gnt, rsp_valid, rsp_sum, rsp_err
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, rsp_valid, rsp_sum, rsp_err
  );

endinterface

// File: rtl/fpadd_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at ptr+1 and wraps, so
// the previously served requester has lowest priority.
//   req   : request vector
//   ptr   : index of the last served requester
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner
//   any   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// ---------------------------------------------------------------------------
// fpadd_arbiter
// Shares one multi-cycle fpadd between N requesters. Grants round-robin,
// latches the winner's operands, pulses start, waits for done and routes the
// sum back. A watchdog aborts a hung add, resets the adder and answers with
// a qNaN error response.
//   clk       : clock, posedge
//   reset     : synchronous, active-low
//   bus       : client bus (slave modport)
//   busy      : high in every state except IDLE
//   fpa_start : one-cycle start to the adder
//   fpa_reset : one-cycle active-high reset to the adder on abort
//   fpa_a/b   : registered operands, held from grant until the next grant
//   fpa_sum   : adder result
//   fpa_done  : adder completion
// ---------------------------------------------------------------------------
module fpadd_arbiter
  import fpadd_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int ID_W    = $clog2(N),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  fpadd_arbiter_if.slave   bus,
  output logic             busy,
  output logic             fpa_start,
  output logic             fpa_reset,
  output logic [FP_W-1:0]  fpa_a,
  output logic [FP_W-1:0]  fpa_b,
  input  logic [FP_W-1:0]  fpa_sum,
  input  logic             fpa_done
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  // wdog is cleared in ISSUE and steps once per WAIT edge; the edge that
  // would carry it to TIMEOUT-1 is the last WAIT cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 2);

  fsm_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic [WDOG_W-1:0] wdog;

  logic [N-1:0]      win_grant;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // fpa_start is raised together with gnt so it is high during the ISSUE
  // cycle; the adder samples it on the ISSUE edge and drops its old done
  // before the first WAIT edge looks at fpa_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_sum   <= '0;
      busy          <= 1'b0;
      fpa_start     <= 1'b0;
      fpa_reset     <= 1'b0;
      fpa_a         <= '0;
      fpa_b         <= '0;
      wdog          <= '0;
      owner         <= '0;
      rr_ptr        <= ID_W'(N - 1);
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      fpa_start     <= 1'b0;
      fpa_reset     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (win_any) begin
            bus.gnt   <= win_grant;
            fpa_a     <= bus.op_a[win_idx*FP_W +: FP_W];
            fpa_b     <= bus.op_b[win_idx*FP_W +: FP_W];
            owner     <= win_idx;
            rr_ptr    <= win_idx;
            fpa_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end

        // done is checked before the watchdog so a completion on the
        // timeout cycle still returns a normal result
        WAIT: begin
          if (fpa_done) begin
            bus.rsp_sum <= fpa_sum;
            state       <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
            if (wdog == WDOG_LAST) begin
              state <= ABORT;
            end
          end
        end

        RESP: begin
          bus.rsp_valid <= {{(N-1){1'b0}}, 1'b1} << owner;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        ABORT: begin
          fpa_reset     <= 1'b1;
          bus.rsp_valid <= {{(N-1){1'b0}}, 1'b1} << owner;
          bus.rsp_err   <= 1'b1;
          bus.rsp_sum   <= FP_QNAN;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpadd_arbiter
// Directed bench for fpadd_arbiter (N=4, TIMEOUT=64) with a behavioural
// adder stub whose latency or hang behaviour is set per operation. Expected
// responses are queued when a request is raised and checked as the DUT
// grants and answers.
// ---------------------------------------------------------------------------
module tb_fpadd_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        fpa_start;
  logic        fpa_reset;
  logic [31:0] fpa_a;
  logic [31:0] fpa_b;
  logic [31:0] fpa_sum;
  logic        fpa_done;

  fpadd_arbiter_if #(.N(N)) bus ();

  fpadd_arbiter #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .fpa_start (fpa_start),
    .fpa_reset (fpa_reset),
    .fpa_a     (fpa_a),
    .fpa_b     (fpa_b),
    .fpa_sum   (fpa_sum),
    .fpa_done  (fpa_done)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   gnt_count = 0;
  int   rsp_count = 0;
  int   rst_pulses = 0;
  int   abandon_cnt = 0;
  int   abandon_seen = 0;
  bit   cur_valid = 0;
  exp_t cur;
  exp_t exp_q[$];
  exp_t rearm[N];
  bit   rearm_valid[N];
  int   stub_lat = 1;
  bit   stub_hang = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] sum,
                              input logic err, input int lat);
    exp_t e;
    e.idx = idx; e.a = a; e.b = b; e.sum = sum; e.err = err; e.lat = lat;
    return e;
  endfunction

  // reference sums for the operand pairs this bench uses
  function automatic logic [31:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b);
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a == {~b[31], b[30:0]}) return 32'h0000_0000;
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4040_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // adder stub: done rises stub_lat negedges after start is seen and is
  // held until the next start or an adder reset
  initial begin
    int  cnt;
    bit  active;
    cnt = 0; active = 0;
    fpa_done = 1'b0;
    fpa_sum  = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset || fpa_reset) begin
        fpa_done = 1'b0;
        active   = 0;
      end else if (fpa_start) begin
        fpa_done = 1'b0;
        active   = 1;
        cnt      = stub_lat;
        if (!stub_hang && cnt == 0) begin
          fpa_done = 1'b1;
          fpa_sum  = ref_add(fpa_a, fpa_b);
          active   = 0;
        end
      end else if (active && !stub_hang) begin
        if (cnt > 0) cnt--;
        if (cnt == 0) begin
          fpa_done = 1'b1;
          fpa_sum  = ref_add(fpa_a, fpa_b);
          active   = 0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (abandon_cnt != abandon_seen) begin
        abandon_seen = abandon_cnt;
        cur_valid    = 0;
      end
      if (fpa_reset) rst_pulses++;
      if (bus.gnt != '0) begin
        gnt_count++;
        if (exp_q.size() == 0) begin
          checkOutput("gnt_unexpected", 32'(bus.gnt), 32'd0);
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1;
          gnt_cyc   = cyc;
          checkOutput("gnt_onehot", 32'(bus.gnt), 32'd1 << cur.idx);
          checkOutput("fpa_a_latch", fpa_a, cur.a);
          checkOutput("fpa_b_latch", fpa_b, cur.b);
        end
      end else if (cur_valid && busy) begin
        checkOutput("fpa_a_hold", fpa_a, cur.a);
        checkOutput("fpa_b_hold", fpa_b, cur.b);
      end
      if (bus.rsp_valid != '0) begin
        rsp_count++;
        if (!cur_valid) begin
          checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          checkOutput("rsp_onehot", 32'(bus.rsp_valid), 32'd1 << cur.idx);
          checkOutput("rsp_sum", bus.rsp_sum, cur.sum);
          checkOutput("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
          checkOutput("rsp_latency", 32'(cyc - gnt_cyc), 32'(cur.lat));
          cur_valid = 0;
        end
      end else if (bus.rsp_err) begin
        checkOutput("rsp_err_without_valid", 32'(bus.rsp_err), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input exp_t e);
    exp_q.push_back(e);
    bus.op_a[e.idx*32 +: 32] = e.a;
    bus.op_b[e.idx*32 +: 32] = e.b;
    bus.req[e.idx] = 1'b1;
  endtask

  // requesters drop req on their grant and optionally re-raise on response
  task automatic serviceRequesters();
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) bus.req[i] = 1'b0;
      if (bus.rsp_valid[i] && rearm_valid[i]) begin
        rearm_valid[i] = 0;
        applyStimulus(rearm[i]);
      end
    end
  endtask

  task automatic waitResponses(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_count < target && n < budget) begin
      @(negedge clk);
      serviceRequesters();
      n++;
    end
    checkOutput("wait_rsp", 32'(rsp_count), 32'(target));
  endtask

  task automatic waitGrants(input int target, input int budget);
    int n;
    n = 0;
    while (gnt_count < target && n < budget) begin
      @(negedge clk);
      serviceRequesters();
      n++;
    end
    checkOutput("wait_gnt", 32'(gnt_count), 32'(target));
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, "_gnt"},       32'(bus.gnt),       32'd0);
    checkOutput({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({pfx, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    checkOutput({pfx, "_rsp_sum"},   bus.rsp_sum,        32'd0);
    checkOutput({pfx, "_busy"},      32'(busy),          32'd0);
    checkOutput({pfx, "_fpa_start"}, 32'(fpa_start),     32'd0);
    checkOutput({pfx, "_fpa_reset"}, 32'(fpa_reset),     32'd0);
    checkOutput({pfx, "_fpa_a"},     fpa_a,              32'd0);
    checkOutput({pfx, "_fpa_b"},     fpa_b,              32'd0);
  endtask

  initial begin
    int pulses_before;
    reset    = 1'b0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    for (int i = 0; i < N; i++) rearm_valid[i] = 0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] round-robin with all four requesters");
    stub_lat = 1;
    applyStimulus(mk(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 3));
    applyStimulus(mk(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 1'b0, 3));
    applyStimulus(mk(2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 3));
    applyStimulus(mk(3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3));
    rearm[0]       = mk(0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 1'b0, 3);
    rearm_valid[0] = 1;
    waitResponses(5, 100);
    checkOutput("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] single op 1.0 + 2.0");
    applyStimulus(mk(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 3));
    waitResponses(rsp_count + 1, 20);

    $display("[TB] cancellation 3.0 + -3.0");
    stub_lat = 2;
    applyStimulus(mk(1, 32'h4040_0000, 32'hC040_0000, 32'h0000_0000, 1'b0, 4));
    waitResponses(rsp_count + 1, 20);

    $display("[TB] zero operand passes b through");
    stub_lat = 5;
    applyStimulus(mk(2, 32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000, 1'b0, 7));
    waitResponses(rsp_count + 1, 20);

    $display("[TB] hung adder triggers abort");
    pulses_before = rst_pulses;
    stub_hang = 1;
    applyStimulus(mk(3, 32'h4000_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, TIMEOUT + 1));
    waitResponses(rsp_count + 1, 100);
    repeat (2) @(negedge clk);
    checkOutput("abort_reset_pulses", 32'(rst_pulses - pulses_before), 32'd1);
    stub_hang = 0;

    $display("[TB] normal op after abort");
    stub_lat = 1;
    applyStimulus(mk(3, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 1'b0, 3));
    waitResponses(rsp_count + 1, 20);

    $display("[TB] done on the timeout cycle");
    pulses_before = rst_pulses;
    stub_lat = TIMEOUT - 1;
    applyStimulus(mk(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 1'b0, TIMEOUT + 1));
    waitResponses(rsp_count + 1, 100);
    checkOutput("edge_no_reset_pulse", 32'(rst_pulses - pulses_before), 32'd0);

    $display("[TB] done one cycle after the timeout cycle");
    stub_lat = TIMEOUT;
    applyStimulus(mk(2, 32'h4000_0000, 32'h4000_0000, 32'h7FC0_0000, 1'b1, TIMEOUT + 1));
    waitResponses(rsp_count + 1, 100);
    repeat (2) @(negedge clk);
    checkOutput("late_reset_pulses", 32'(rst_pulses - pulses_before), 32'd1);

    $display("[TB] reset during WAIT");
    stub_hang = 1;
    applyStimulus(mk(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3));
    waitGrants(gnt_count + 1, 20);
    repeat (3) begin
      @(negedge clk);
      serviceRequesters();
    end
    checkOutput("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    abandon_cnt++;
    @(negedge clk);
    checkIdleOutputs("midrst");
    @(negedge clk);
    reset     = 1'b1;
    stub_hang = 0;
    stub_lat  = 1;
    applyStimulus(mk(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 3));
    applyStimulus(mk(2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 1'b0, 3));
    waitResponses(rsp_count + 2, 40);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
Shares one multi-cycle fpadd instance between N requesters using round-robin arbitration. The block handles the fpadd sequencing:
- issues a one-cycle start
- holds the operands stable for the whole operation
- waits for done
- routes the sum back to the owning requester

A watchdog aborts a hung operation, resets the adder, and returns an error response. It sits between client units (e.g. accumulate or dot-product sequencers) and the shared adder.

Parameters:
N, 4, number of requesters (2..16)
ID_W, $clog2(N), requester index width
TIMEOUT, 64, maximum cycles in WAIT before abort (>= 32)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset (asserted when 0)
req  in  N  per-requester request level; requester holds it with operands until its gnt bit pulses
op_a  in  N*32  flattened IEEE-754 operand A; slot i is bits [32i+31:32i]
op_b  in  N*32  flattened operand B, same packing
gnt  out  N  one-hot, one-cycle pulse: request accepted and operands latched
rsp_valid  out  N  one-hot, one-cycle pulse to the owning requester
rsp_sum  out  32  result; valid while any rsp_valid bit is high
rsp_err  out  1  high with rsp_valid on a timeout abort
busy  out  1  high in every state except IDLE
fpa_start  out  1  to fpadd start
fpa_reset  out  1  to fpadd reset (active-high on the adder side)
fpa_a  out  32  to fpadd a, registered
fpa_b  out  32  to fpadd b, registered
fpa_sum  in  32  from fpadd sum
fpa_done  in  1  from fpadd done

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; gnt, rsp_valid, rsp_err, fpa_start, fpa_reset, busy = 0
  - fpa_a, fpa_b, rsp_sum = 0; wdog=0; owner=0
  - rr_ptr=N-1, so requester 0 has first priority
  - Reset mid-operation abandons the operation silently: no response, adder state ignored.
- States: IDLE, ISSUE, WAIT, RESP, ABORT.
- IDLE: winner = first set req bit searching from rr_ptr+1 with wrap. If any req is set, in the same cycle:
  - gnt[winner]=1; fpa_a/fpa_b <= winner's slot
  - owner <= winner; rr_ptr <= winner; go to ISSUE
- IDLE with no req: outputs stay 0. A request withdrawn before it is granted is legal and is not granted.
- ISSUE: fpa_start=1 for exactly one cycle; wdog <= 0; go to WAIT.
  - fpadd clears done on this edge, so stale done from the previous op is never sampled.
- WAIT: fpa_start=0.
  - fpa_done=1: rsp_sum <= fpa_sum; go to RESP.
  - Otherwise wdog++. When wdog reaches TIMEOUT-1: go to ABORT.
  - fpa_done and timeout in the same cycle: done wins.
- RESP (1 cycle): rsp_valid[owner]=1, rsp_err=0; go to IDLE. The next grant is earliest in the following cycle.
- ABORT (1 cycle):
  - fpa_reset=1; rsp_valid[owner]=1, rsp_err=1
  - rsp_sum=32'h7FC00000 (qNaN); go to IDLE
- fpa_a/fpa_b hold from grant until the next grant. fpadd reads a/b live on special-case paths, so they must never change mid-operation.
- Minimum turnaround for one request: grant cycle + ISSUE + WAIT cycles + RESP. A done seen on the first WAIT cycle gives rsp_valid 3 cycles after gnt.
- Fairness: under continuous requests from all N requesters, each is served once per N operations.
- Width rules:
  - wdog width = $clog2(TIMEOUT).
  - rr_ptr wrap: after N-1 comes 0.
  - Operand slice index uses owner*32; no arithmetic is done on data.

Decomposition:
- Shared package fpadd_ctrl_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP, ABORT)
  - FP_W=32
  - FP_QNAN=32'h7FC00000
  - default TIMEOUT
- One sub-module, rr_arbiter: combinational req + rr_ptr -> one-hot grant + index, parameter N. It is reusable by other shared-unit controllers.
- The FSM, watchdog and operand registers live in fpadd_arbiter.

Test Plan:
- Single op, paired with real fpadd: req[0], a=0x3F800000 (1.0), b=0x40000000 (2.0) -> gnt[0] one cycle; later rsp_valid[0] with rsp_sum=0x40400000 and rsp_err=0.
- Round-robin fairness:
  - all four req held, each request given distinct operands; requester i re-raises req after its response
  - grant order 0,1,2,3,0.
  - each rsp_valid index matches the gnt index; sums correct (e.g. 1.5+1.5=0x40400000)
- Cancellation and special case:
  - a=0x40400000 (3.0), b=0xC0400000 (-3.0) -> rsp_sum with exponent 0, no error.
  - a=0 -> rsp_sum=b; fpa_a/fpa_b stable throughout.
- Timeout, with an adder stub holding done=0:
  - ABORT at cycle TIMEOUT after ISSUE
  - fpa_reset pulses once
  - rsp_err=1, rsp_sum=0x7FC00000
  - the next request is then served normally
- Boundary events:
  - stub raises done exactly on the timeout cycle -> normal response, rsp_err=0.
  - reset driven low during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid; after release, req[2] and req[0] together -> gnt[0] first.
